// File: rtl/des_round_ctrl.sv
// Sequencing FSM for an iterative DES datapath: IP/key load, NUM_ROUNDS Feistel rounds, FP capture, result hold.
// Define DES_ROUND_STALL_EN to add the round_stall input that freezes round progress.
module des_round_ctrl #(
  parameter int NUM_ROUNDS   = 16,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       decrypt,
`ifdef DES_ROUND_STALL_EN
  input  logic       round_stall,
`endif
  output logic       ip_load,
  output logic       key_load,
  output logic       round_en,
  output logic [4:0] round_num,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       fp_load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);
  localparam logic [2:0] LAST_SUB   = 3'(ROUND_CYCLES - 1);

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic [4:0] round_q, round_d;
  logic [2:0] sub_q, sub_d;
  logic       stall;
  logic       last_sub;

`ifdef DES_ROUND_STALL_EN
  assign stall = round_stall;
`else
  assign stall = 1'b0;
`endif

  assign last_sub = (sub_q == LAST_SUB) && !stall;

  // Decrypt runs the schedule backwards: round 1 reuses the untouched PC-1 key.
  function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dir);
    case (rnd)
      5'd1:               shift_amt = dir ? 2'd0 : 2'd1;
      5'd2, 5'd9, 5'd16:  shift_amt = 2'd1;
      default:            shift_amt = 2'd2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      round_q <= 5'd0;
      sub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    round_d = round_q;
    sub_d   = sub_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          mode_d  = decrypt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        round_d = 5'd1;
        sub_d   = 3'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!stall) begin
          if (sub_q == LAST_SUB) begin
            sub_d = 3'd0;
            if (round_q == LAST_ROUND) begin
              round_d = 5'd0;
              state_d = S_FINAL;
            end else begin
              round_d = round_q + 5'd1;
            end
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
      end
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == S_IDLE);
    ip_load     = (state_q == S_LOAD);
    key_load    = (state_q == S_LOAD);
    round_en    = (state_q == S_ROUND) && last_sub;
    round_num   = (state_q == S_ROUND) ? round_q : 5'd0;
    key_shift   = round_en ? shift_amt(round_q, mode_q) : 2'd0;
    key_dir     = round_en && mode_q;
    fp_load     = (state_q == S_FINAL);
    out_valid   = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: two instances (ROUND_CYCLES 1 and 3) checked cycle by cycle against a schedule model.
// Build with DES_ROUND_STALL_EN to exercise the round stall on the ROUND_CYCLES=3 instance.
module tb_des_round_ctrl;
  localparam int N = 16;
`ifdef DES_ROUND_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif
  // {start_ready, ip_load, key_load, round_en, round_num[4:0], key_shift[1:0], key_dir, fp_load, out_valid, busy}
  localparam logic [14:0] IDLE_V = 15'h4000;
  localparam logic [1:0] ENC_TAB [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                          2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] DEC_TAB [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                          2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sv [2];
  logic dec [2];
  logic ordy [2];
  logic stall;
  wire [14:0] ov [2];
  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire sr, ipl, kl, ren, kd, fpl, ovl, bsy;
    wire [4:0] rn;
    wire [1:0] ks;
    des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_CYCLES(g == 1 ? 3 : 1)) u_dut (
      .clk(clk), .rst(rst),
      .start_valid(sv[g]), .start_ready(sr), .decrypt(dec[g]),
`ifdef DES_ROUND_STALL_EN
      .round_stall((g == 1) ? stall : 1'b0),
`endif
      .ip_load(ipl), .key_load(kl), .round_en(ren), .round_num(rn),
      .key_shift(ks), .key_dir(kd), .fp_load(fpl), .out_valid(ovl),
      .out_ready(ordy[g]), .busy(bsy)
    );
    assign ov[g] = {sr, ipl, kl, ren, rn, ks, kd, fpl, ovl, bsy};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] v, input int s);
    return (v << s) | (v >> (28 - s));
  endfunction

  // Expected outputs w cycles after the start handshake (w counts non-stalled cycles).
  function automatic logic [14:0] model(input int rc, input int w, input bit d, input bit stl);
    logic [14:0] v;
    int rnd;
    bit en;
    v = '0;
    v[0] = 1'b1;
    if (w == 1) begin
      v[13] = 1'b1;
      v[12] = 1'b1;
    end else if (w <= 1 + N * rc) begin
      rnd = (w - 2) / rc + 1;
      en = (((w - 2) % rc) == rc - 1) && !stl;
      v[10:6] = 5'(rnd);
      v[11] = en;
      if (en) begin
        v[5:4] = d ? DEC_TAB[rnd-1] : ENC_TAB[rnd-1];
        v[3] = d;
      end
    end else if (w == 2 + N * rc) begin
      v[2] = 1'b1;
    end else begin
      v[1] = 1'b1;
    end
    return v;
  endfunction

  task automatic run_block(input int g, input bit d, input int hold, input int abort_rnd,
                           input int st_rnd, input int st_len);
    int rc, w, donecnt, ren, ssum, stall_left, lat, rnd, exp_lat;
    bit fin, stl, in_round, in_done;
    logic [14:0] ev;
    logic [27:0] c0, c;
    rc = (g == 1) ? 3 : 1;
    w = 1; donecnt = 0; ren = 0; ssum = 0; stall_left = st_len; lat = 0; fin = 1'b0;
    c0 = 28'($urandom);
    c = c0;
    @(negedge clk);
    sv[g] = 1'b1;
    dec[g] = d;
    ordy[g] = 1'($urandom);
    stall = 1'b0;
    #1 chk($sformatf("ready_at_start g%0d", g), 32'(ov[g]), 32'(IDLE_V));
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk);
      in_round = (w >= 2) && (w <= 1 + N * rc);
      in_done = (w >= 3 + N * rc);
      rnd = in_round ? (w - 2) / rc + 1 : 0;
      sv[g] = (in_done && donecnt >= hold) ? 1'b0 : 1'($urandom);
      dec[g] = 1'($urandom);
      ordy[g] = in_done ? (donecnt >= hold) : 1'($urandom);
      if (g == 1 && in_round && rnd == st_rnd && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else if (g == 1 && !in_round) begin
        stall = 1'($urandom);
      end else begin
        stall = 1'b0;
      end
      stl = HAS_STALL && (g == 1) && in_round && stall;
      #1;
      ev = model(rc, w, d, stl);
      chk($sformatf("trace g%0d d%0d w%0d", g, d, w), 32'(ov[g]), 32'(ev));
      if (ov[g][1] && lat == 0) lat = cyc;
      if (ov[g][11]) begin
        ren++;
        ssum += int'(ov[g][5:4]);
        c = ov[g][3] ? rotl(c, (28 - int'(ov[g][5:4])) % 28) : rotl(c, int'(ov[g][5:4]));
      end
      if (abort_rnd != 0 && rnd == abort_rnd) begin
        rst = 1'b1;
        sv[g] = 1'b0;
        @(negedge clk);
        #1 chk($sformatf("abort_to_idle g%0d", g), 32'(ov[g]), 32'(IDLE_V));
        rst = 1'b0;
        @(negedge clk);
        #1 chk($sformatf("abort_stays_idle g%0d", g), 32'(ov[g]), 32'(IDLE_V));
        return;
      end
      if (in_done) begin
        if (ordy[g]) fin = 1'b1;
        donecnt++;
      end else if (!stl) begin
        w++;
      end
    end
    exp_lat = 3 + N * rc + ((HAS_STALL && g == 1 && st_rnd > 0) ? st_len : 0);
    chk($sformatf("completed g%0d", g), 32'(fin), 32'd1);
    chk($sformatf("round_en_count g%0d", g), 32'(ren), 32'(N));
    chk($sformatf("shift_sum g%0d d%0d", g, d), 32'(ssum), d ? 32'd27 : 32'd28);
    chk($sformatf("key_rotation g%0d d%0d", g, d), 32'(c), 32'(d ? rotl(c0, 1) : c0));
    chk($sformatf("latency g%0d", g), 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0;
      dec[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1 chk("reset_state g0", 32'(ov[0]), 32'(IDLE_V));
    chk("reset_state g1", 32'(ov[1]), 32'(IDLE_V));
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1 chk("idle g0", 32'(ov[0]), 32'(IDLE_V));
      chk("idle g1", 32'(ov[1]), 32'(IDLE_V));
    end
    // Encrypt then decrypt, single-cycle rounds.
    run_block(0, 1'b0, 0, 0, 0, 0);
    run_block(0, 1'b1, 0, 0, 0, 0);
    // Consumer holds off for 10 clocks, then a back-to-back block.
    run_block(0, 1'b0, 10, 0, 0, 0);
    run_block(0, 1'b1, 0, 0, 0, 0);
    // Reset during round 7, then a clean block.
    run_block(0, 1'b0, 0, 7, 0, 0);
    run_block(0, 1'b0, 0, 0, 0, 0);
    // Three clocks per round, with a 4-clock stall in round 5.
    run_block(1, 1'b0, 0, 0, 5, 4);
    run_block(1, 1'b1, 2, 0, 0, 0);
    run_block(1, 1'b0, 0, 3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_block(i % 2, 1'($urandom), $urandom_range(0, 3), 0,
                $urandom_range(1, 16), $urandom_range(1, 5));
    end
    @(negedge clk);
    #1 chk("final_idle g0", 32'(ov[0]), 32'(IDLE_V));
    chk("final_idle g1", 32'(ov[1]), 32'(IDLE_V));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
